// File: rtl/pipe_tree_mux_pkg.sv
// Shared geometry helpers for the pipelined selection tree.
// Every helper is evaluated at elaboration time to size stages and their word counts.
package trv_mux_pkg;

  function automatic int num_stages(input int levels, input int per_stage);
    return (levels + per_stage - 1) / per_stage;
  endfunction

  // Surviving word count after `level` pairwise reductions; missing partners are zero padding.
  function automatic int words_after(input int level, input int num_inputs);
    return (num_inputs + (1 << level) - 1) >> level;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_tree_mux_stage.sv
// One register slice of the selection tree: a few pairwise reduction levels
// followed by a one-entry elastic register.
module pipe_tree_mux_stage
  import trv_mux_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IN_WORDS  = 2,
  parameter int LEVELS_DO = 1,
  parameter int SEL_W     = 1,
  localparam int OUT_WORDS = words_after(LEVELS_DO, IN_WORDS),
  localparam int OUT_SEL_W = (SEL_W > LEVELS_DO) ? SEL_W - LEVELS_DO : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [IN_WORDS*WIDTH-1:0]  words_i,
  input  logic [SEL_W-1:0]           sel_i,
  input  logic                       err_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [OUT_WORDS*WIDTH-1:0] words_o,
  output logic [OUT_SEL_W-1:0]       sel_o,
  output logic                       err_o
);

  localparam int PAD_WORDS = OUT_WORDS << LEVELS_DO;

  logic [WIDTH-1:0]           tree [LEVELS_DO+1][PAD_WORDS];
  logic [OUT_WORDS*WIDTH-1:0] reduced;
  logic [OUT_SEL_W-1:0]       sel_next;

  logic                       valid_q;
  logic [OUT_WORDS*WIDTH-1:0] words_q;
  logic [OUT_SEL_W-1:0]       sel_q;
  logic                       err_q;

  // Each level uses the lowest select bit still unconsumed; an errored request yields zero words.
  always_comb begin
    for (int l = 0; l <= LEVELS_DO; l++)
      for (int j = 0; j < PAD_WORDS; j++)
        tree[l][j] = '0;
    for (int j = 0; j < IN_WORDS; j++)
      tree[0][j] = words_i[j*WIDTH +: WIDTH];
    for (int l = 0; l < LEVELS_DO; l++)
      for (int j = 0; j < (PAD_WORDS >> (l + 1)); j++)
        tree[l+1][j] = sel_i[l] ? tree[l][2*j+1] : tree[l][2*j];
    reduced = '0;
    for (int j = 0; j < OUT_WORDS; j++)
      reduced[j*WIDTH +: WIDTH] = err_i ? '0 : tree[LEVELS_DO][j];
  end

  if (SEL_W > LEVELS_DO) begin : g_sel_pass
    assign sel_next = sel_i[SEL_W-1:LEVELS_DO];
  end else begin : g_sel_done
    assign sel_next = '0;
  end

  assign ready_o = !valid_q || ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      words_q <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        words_q <= reduced;
        sel_q   <= sel_next;
        err_q   <= err_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign words_o = words_q;
  assign sel_o   = sel_q;
  assign err_o   = err_q;

endmodule

// File: rtl/pipe_tree_mux.sv
// Pipelined, flow-controlled N:1 selection tree; the binary reduction is cut
// into register slices of LEVELS_PER_STAGE levels each.
module pipe_tree_mux
  import trv_mux_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int NUM_INPUTS       = 8,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int SELECT_BITS      = $clog2(NUM_INPUTS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [WIDTH-1:0]       data_i [NUM_INPUTS],
  input  logic [SELECT_BITS-1:0] sel_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   err_o
);

  localparam int LEVELS     = SELECT_BITS;
  localparam int NUM_STAGES = num_stages(LEVELS, LEVELS_PER_STAGE);

  logic sel_err;

  assign sel_err = 32'(sel_i) >= 32'(NUM_INPUTS);

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int LVL_LO    = k * LEVELS_PER_STAGE;
    localparam int LVL_DO    = min_int(LEVELS_PER_STAGE, LEVELS - LVL_LO);
    localparam int IN_WORDS  = words_after(LVL_LO, NUM_INPUTS);
    localparam int OUT_WORDS = words_after(LVL_LO + LVL_DO, NUM_INPUTS);
    localparam int SEL_W     = LEVELS - LVL_LO;
    localparam int OUT_SEL_W = (SEL_W > LVL_DO) ? SEL_W - LVL_DO : 1;

    logic [IN_WORDS*WIDTH-1:0]  words_in;
    logic [SEL_W-1:0]           sel_in;
    logic                       err_in;
    logic                       valid_in;
    logic                       ready_up;
    logic                       ready_dn;
    logic [OUT_WORDS*WIDTH-1:0] words_out;
    logic [OUT_SEL_W-1:0]       sel_out;
    logic                       err_out;
    logic                       valid_out;

    if (k == 0) begin : g_first
      for (genvar j = 0; j < NUM_INPUTS; j++) begin : g_pack
        assign words_in[j*WIDTH +: WIDTH] = data_i[j];
      end
      assign sel_in   = sel_i;
      assign err_in   = sel_err;
      assign valid_in = valid_i;
    end else begin : g_chain
      assign words_in = g_stage[k-1].words_out;
      assign sel_in   = g_stage[k-1].sel_out;
      assign err_in   = g_stage[k-1].err_out;
      assign valid_in = g_stage[k-1].valid_out;
    end

    // The final stage has no select bits left; its one-bit leftover select output is intentionally dropped.
    if (k == NUM_STAGES - 1) begin : g_last
      logic unused_sel;
      assign ready_dn   = ready_i;
      assign unused_sel = ^sel_out;
    end else begin : g_mid
      assign ready_dn = g_stage[k+1].ready_up;
    end

    pipe_tree_mux_stage #(
      .WIDTH    (WIDTH),
      .IN_WORDS (IN_WORDS),
      .LEVELS_DO(LVL_DO),
      .SEL_W    (SEL_W)
    ) u_stage (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .valid_i(valid_in),
      .ready_o(ready_up),
      .words_i(words_in),
      .sel_i  (sel_in),
      .err_i  (err_in),
      .valid_o(valid_out),
      .ready_i(ready_dn),
      .words_o(words_out),
      .sel_o  (sel_out),
      .err_o  (err_out)
    );
  end

  assign ready_o = g_stage[0].ready_up;
  assign valid_o = g_stage[NUM_STAGES-1].valid_out;
  assign data_o  = g_stage[NUM_STAGES-1].words_out;
  assign err_o   = g_stage[NUM_STAGES-1].err_out;

endmodule

// File: tb/tb_pipe_tree_mux.sv
// Self-checking bench for pipe_tree_mux: three geometries (5 inputs / 3 stages,
// 8 inputs / 2 stages, 2 inputs / 1 stage), table vectors, stall and reset sequences, random scoreboard.
module tb_pipe_tree_mux;

  localparam int NREQ = 10000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 5 inputs, one level per stage -> 3 stages
  logic        a_valid, a_ready_o, a_valid_o, a_ready_i, a_err_o;
  logic [31:0] a_data [5];
  logic [2:0]  a_sel;
  logic [31:0] a_data_o;

  // Instance B: default geometry, 8 inputs -> 2 stages
  logic        b_valid, b_ready_o, b_valid_o, b_ready_i, b_err_o;
  logic [31:0] b_data [8];
  logic [2:0]  b_sel;
  logic [31:0] b_data_o;

  // Instance C: 2 inputs, 3 levels per stage -> 1 stage
  logic        c_valid, c_ready_o, c_valid_o, c_ready_i, c_err_o;
  logic [31:0] c_data [2];
  logic [0:0]  c_sel;
  logic [31:0] c_data_o;

  pipe_tree_mux #(.WIDTH(32), .NUM_INPUTS(5), .LEVELS_PER_STAGE(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(a_valid), .ready_o(a_ready_o),
    .data_i(a_data), .sel_i(a_sel), .valid_o(a_valid_o), .ready_i(a_ready_i),
    .data_o(a_data_o), .err_o(a_err_o)
  );

  pipe_tree_mux dut_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(b_valid), .ready_o(b_ready_o),
    .data_i(b_data), .sel_i(b_sel), .valid_o(b_valid_o), .ready_i(b_ready_i),
    .data_o(b_data_o), .err_o(b_err_o)
  );

  pipe_tree_mux #(.WIDTH(32), .NUM_INPUTS(2), .LEVELS_PER_STAGE(3)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(c_valid), .ready_o(c_ready_o),
    .data_i(c_data), .sel_i(c_sel), .valid_o(c_valid_o), .ready_i(c_ready_i),
    .data_o(c_data_o), .err_o(c_err_o)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl [9];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [2:0] s, input logic r);
    @(posedge clk);
    #1;
    a_valid   = v;
    a_sel     = s;
    a_ready_i = r;
  endtask

  // Reference: an in-range select forwards that word, anything else flags an error with zero data.
  function automatic logic [32:0] ref_a(input logic [2:0] s, input logic [31:0] w);
    return (int'(s) >= 5) ? {1'b1, 32'h0} : {1'b0, w};
  endfunction

  logic [32:0] exp_q [$];
  logic [32:0] held, exp_word;
  logic        hold_pending;
  int          pushed, cycles;

  initial begin
    tbl[0] = '{3'd0, 32'h100, 1'b0};
    tbl[1] = '{3'd1, 32'h101, 1'b0};
    tbl[2] = '{3'd2, 32'h102, 1'b0};
    tbl[3] = '{3'd3, 32'h103, 1'b0};
    tbl[4] = '{3'd4, 32'h104, 1'b0};
    tbl[5] = '{3'd5, 32'h0,   1'b1};
    tbl[6] = '{3'd7, 32'h0,   1'b1};
    tbl[7] = '{3'd4, 32'h104, 1'b0};
    tbl[8] = '{3'd6, 32'h0,   1'b1};

    rst_n = 1'b0;
    a_valid = 0; a_sel = 0; a_ready_i = 1;
    b_valid = 0; b_sel = 0; b_ready_i = 1;
    c_valid = 0; c_sel = 0; c_ready_i = 1;
    for (int j = 0; j < 5; j++) a_data[j] = 32'h100 + j;
    for (int j = 0; j < 8; j++) b_data[j] = 32'h200 + j;
    c_data[0] = 32'hAAAA_0000;
    c_data[1] = 32'h5555_0001;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_a_outputs", {a_valid_o, a_err_o, a_data_o}, 64'h0);
    check_output("reset_a_ready", a_ready_o, 1);
    check_output("reset_b_ready", b_ready_o, 1);
    check_output("reset_c_valid", c_valid_o, 0);
    rst_n = 1'b1;

    // Back-to-back table vectors through the 3-stage instance
    for (int c = 0; c < 12; c++) begin
      if (c < 9) apply_stimulus(1'b1, tbl[c].sel, 1'b1);
      else       apply_stimulus(1'b0, 3'd0, 1'b1);
      @(negedge clk);
      if (c >= 3)
        check_output($sformatf("table_a_vec%0d", c - 3), {a_valid_o, a_err_o, a_data_o},
                     {31'h0, 1'b1, tbl[c-3].exp_err, tbl[c-3].exp_data});
      else
        check_output($sformatf("table_a_latency%0d", c), a_valid_o, 0);
    end

    // Stall on the 2-stage instance: ready_o drops after two accepts
    @(posedge clk); #1;
    b_ready_i = 0; b_valid = 1; b_sel = 3'd3;
    @(negedge clk); check_output("stall_b_accept0", b_ready_o, 1);
    @(posedge clk); #1; b_sel = 3'd6;
    @(negedge clk); check_output("stall_b_accept1", b_ready_o, 1);
    @(posedge clk); #1; b_sel = 3'd1;
    @(negedge clk);
    check_output("stall_b_full", {b_ready_o, b_valid_o, b_err_o, b_data_o}, {30'h0, 2'b01, 1'b0, 32'h203});
    @(posedge clk); #1;
    @(negedge clk);
    check_output("stall_b_hold", {b_ready_o, b_valid_o, b_data_o}, {30'h0, 2'b01, 32'h203});
    @(posedge clk); #1; b_ready_i = 1;
    @(negedge clk);
    check_output("stall_b_pulse", {b_ready_o, b_valid_o, b_data_o}, {30'h0, 2'b11, 32'h203});
    @(posedge clk); #1; b_ready_i = 0; b_sel = 3'd7;
    @(negedge clk);
    check_output("stall_b_after_pulse", {b_ready_o, b_valid_o, b_data_o}, {30'h0, 2'b01, 32'h206});
    @(posedge clk); #1;
    @(negedge clk);
    check_output("stall_b_hold2", {b_valid_o, b_data_o}, {31'h0, 1'b1, 32'h206});
    @(posedge clk); #1; b_ready_i = 1; b_valid = 0;
    @(negedge clk); check_output("drain_b_0", {b_valid_o, b_data_o}, {31'h0, 1'b1, 32'h206});
    @(posedge clk); #1;
    @(negedge clk); check_output("drain_b_1", {b_valid_o, b_data_o}, {31'h0, 1'b1, 32'h201});
    @(posedge clk); #1;
    @(negedge clk); check_output("drain_b_empty", b_valid_o, 0);

    // Single-stage instance: latency of one register
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      c_valid = (c < 4);
      c_sel   = 1'((c == 1 || c == 2) ? 1 : 0);
      @(negedge clk);
      if (c == 0)
        check_output("c_latency", c_valid_o, 0);
      else
        check_output($sformatf("c_vec%0d", c - 1), {c_valid_o, c_err_o, c_data_o},
                     {31'h0, 1'b1, 1'b0, ((c == 2 || c == 3) ? 32'h5555_0001 : 32'hAAAA_0000)});
    end
    @(posedge clk); #1; c_valid = 0;

    // Asynchronous reset with two requests in flight
    apply_stimulus(1'b1, 3'd1, 1'b0);
    apply_stimulus(1'b1, 3'd4, 1'b0);
    apply_stimulus(1'b0, 3'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("inflight_a_before_reset", {a_valid_o, a_data_o}, {31'h0, 1'b1, 32'h101});
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_a_outputs", {a_valid_o, a_err_o, a_data_o}, 64'h0);
    check_output("async_reset_a_ready", a_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      apply_stimulus(1'b0, 3'd0, 1'b1);
      @(negedge clk);
      check_output($sformatf("post_reset_a_idle%0d", c), a_valid_o, 0);
    end

    // Random valid/ready traffic against the scoreboard
    pushed = 0; cycles = 0; hold_pending = 0;
    while (pushed < NREQ && cycles < 80000) begin
      apply_stimulus((pushed < NREQ) ? 1'($urandom % 2) : 1'b0, 3'($urandom_range(0, 7)), 1'($urandom % 2));
      for (int j = 0; j < 5; j++) a_data[j] = $urandom;
      @(negedge clk);
      cycles++;
      if (hold_pending)
        check_output("rand_a_stable", {a_valid_o, a_err_o, a_data_o}, {31'h0, 1'b1, held});
      if (a_valid && a_ready_o) begin
        exp_q.push_back(ref_a(a_sel, (int'(a_sel) < 5) ? a_data[a_sel] : 32'h0));
        pushed++;
      end
      if (a_valid_o && a_ready_i) begin
        if (exp_q.size() == 0) begin
          check_output("rand_a_spurious", {a_err_o, a_data_o}, 64'h1_FFFF_FFFF_FFFF);
        end else begin
          exp_word = exp_q.pop_front();
          check_output("rand_a_result", {a_err_o, a_data_o}, {31'h0, exp_word});
        end
      end
      hold_pending = a_valid_o && !a_ready_i;
      held = {a_err_o, a_data_o};
    end
    check_output("rand_a_all_pushed", pushed, NREQ);

    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      apply_stimulus(1'b0, 3'd0, 1'b1);
      @(negedge clk);
      if (a_valid_o) begin
        exp_word = exp_q.pop_front();
        check_output("rand_a_drain", {a_err_o, a_data_o}, {31'h0, exp_word});
      end
    end
    check_output("rand_a_queue_empty", exp_q.size(), 0);
    apply_stimulus(1'b0, 3'd0, 1'b1);
    @(negedge clk);
    check_output("rand_a_no_extra", a_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
